// File: rtl/output_buffer.sv
// Per-port router output buffer: queues whole packets in a small FIFO and serializes them MSB-first onto a narrow link.
// Optional statistics counters are enabled with the OUTPUT_BUFFER_STATS_EN macro.
module output_buffer #(
    parameter int DEPTH  = 4,
    parameter int PKT_W  = 32,
    parameter int LINK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              ob_ready_to_recv,
    output logic              put_outbound,
    output logic [LINK_W-1:0] payload_outbound,
    output logic              sop_outbound,
    output logic              eop_outbound,
    input  logic              free_outbound
`ifdef OUTPUT_BUFFER_STATS_EN
    ,
    output logic [15:0]       pkt_sent_count,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int BEATS = PKT_W / LINK_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t            state, state_nxt;
    logic [PKT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic [PKT_W-1:0]  shreg;
    logic [BW-1:0]     beat;
    logic              push, pop, shift, last_beat;

    assign ob_ready_to_recv = (count < CW'(DEPTH));
    assign push             = pkt_in_avail && ob_ready_to_recv;
    assign last_beat        = (beat == BW'(BEATS - 1));

    assign put_outbound     = (state == SEND);
    assign payload_outbound = put_outbound ? shreg[PKT_W-1 -: LINK_W] : '0;
    assign sop_outbound     = put_outbound && (beat == '0);
    assign eop_outbound     = put_outbound && last_beat;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (free_outbound) begin
                    if (!last_beat) begin
                        shift = 1'b1;
                    end else if (count != '0) begin
                        // next packet follows with no idle cycle on the link
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            beat  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                shreg <= mem[rptr];
                beat  <= '0;
            end else if (shift) begin
                shreg <= shreg << LINK_W;
                beat  <= beat + BW'(1);
            end
        end
    end

    // Packet storage needs no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= pkt_in;
    end

`ifdef OUTPUT_BUFFER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_sent_count <= '0;
            stall_cycles   <= '0;
        end else begin
            if (put_outbound && free_outbound && eop_outbound)
                pkt_sent_count <= sat_inc(pkt_sent_count);
            if (put_outbound && !free_outbound)
                stall_cycles <= sat_inc(stall_cycles);
        end
    end
`endif

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Per-port output buffer of the router; one instance on each of the 4 crossbar outputs.
- Accepts whole packets from the routing logic using the pkt_out / pkt_out_avail / ob_ready_to_recv handshake.
- Queues them in a small FIFO.
- Serializes each packet onto a narrow outbound link toward the neighbour node, with a per-beat valid/free handshake.

Parameters:
- DEPTH, 4, FIFO entries (packets); power of 2, minimum 2.
- PKT_W, 32, packet width in bits; must be an integer multiple of LINK_W.
- LINK_W, 8, outbound link width in bits; BEATS = PKT_W/LINK_W.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pkt_in  input  PKT_W  packet from routing logic (its pkt_out[port]).
- pkt_in_avail  input  1  packet valid from routing logic (its pkt_out_avail[port]).
- ob_ready_to_recv  output  1  buffer can accept a packet this cycle.
- put_outbound  output  1  link beat valid.
- payload_outbound  output  LINK_W  link beat data.
- sop_outbound  output  1  first beat of packet.
- eop_outbound  output  1  last beat of packet.
- free_outbound  input  1  neighbour accepts the current beat.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clock edge):
  - FIFO emptied; count=0; FSM=IDLE; beat counter=0; shift register=0.
  - Reset values of outputs: ob_ready_to_recv=1 (combinational from count), put_outbound=0, payload_outbound=0, sop_outbound=0, eop_outbound=0.
- Reset mid-packet: the partial packet and all queued packets are discarded. put_outbound is low in the cycle after the reset edge.
- ob_ready_to_recv = (count < DEPTH). It is derived from registered count only and does not depend on a same-cycle pop.
- Push occurs when pkt_in_avail && ob_ready_to_recv. pkt_in is written at wptr, and wptr wraps modulo DEPTH.
- pkt_in_avail while not ready is a protocol violation: the packet is dropped and FIFO state is unchanged.
- Pop occurs when the FSM loads the FIFO head into the shift register. rptr wraps modulo DEPTH.
- Simultaneous push and pop leaves count unchanged. count width is clog2(DEPTH)+1.
- FSM states: IDLE, SEND.
  - IDLE: put_outbound=0. If count>0, load head into the shift register, pop, set beat=0, and go to SEND.
  - SEND outputs:
    - put_outbound=1.
    - payload_outbound = shreg[PKT_W-1 -: LINK_W] (MSB-first).
    - sop_outbound = (beat==0).
    - eop_outbound = (beat==BEATS-1).
  - SEND, beat accepted and not last (free_outbound=1, beat<BEATS-1): shift left by LINK_W; beat+=1.
  - SEND, beat accepted and last (free_outbound=1, beat==BEATS-1):
    - If count>0: load the next head, pop, set beat=0, and stay in SEND. Packets go back-to-back with no idle cycle.
    - Otherwise go to IDLE.
  - SEND with free_outbound=0: hold all link outputs and state stable. put_outbound never drops mid-packet.
- Latency:
  - Packet pushed at edge N (FIFO and FSM idle) gives first beat valid in cycle N+2.
  - With free_outbound held high, one packet takes BEATS cycles on the link.
- Throughput: 1 packet per BEATS cycles. The FIFO absorbs up to DEPTH packets plus 1 in the shift register.
- A FIFO slot frees at the load edge. ob_ready_to_recv rises the cycle after the load.

Optional Feature:
- Macro: OUTPUT_BUFFER_STATS_EN.
- When defined, two extra output ports exist, both reset to 0 and saturating at 16'hFFFF:
  - pkt_sent_count (16 bits): increments on each accepted eop beat.
  - stall_cycles (16 bits): increments each cycle with put_outbound=1 && free_outbound=0.
- When undefined, both ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Single packet: push 32'hA1B2C3D4 with free_outbound=1 → beats A1 (sop), B2, C3, D4 (eop) in cycles N+2..N+5. put_outbound is low at N+6.
- Fill: hold free_outbound=0 and push 5 packets on consecutive cycles (DEPTH=4) → the first 5 are accepted (1 loaded into the shift register plus 4 queued) and ob_ready_to_recv goes low. A 6th push while not ready is dropped.
- Backpressure: toggle free_outbound 1,0,0,1 mid-packet → payload, sop and eop stay stable during stall cycles. No beat is duplicated or skipped.
- Back-to-back: queue 32'h11111111 and 32'h22222222 with free_outbound=1 → 8 consecutive beats, with eop on 11 immediately followed by sop on 22.
- Reset mid-packet: assert reset after the 2nd beat of a 3-packet queue → put_outbound=0, ob_ready_to_recv=1 and count=0 the next cycle, and no stale beat appears after release.
- Stats (OUTPUT_BUFFER_STATS_EN): send 3 packets with 5 total stall cycles → pkt_sent_count=3, stall_cycles=5.
